snax_cgra_cfg_loader: RTL and testbench

SNAX_CGRA_CFG_LOADER -- requirements
Module: snax_cgra_cfg_loader

---
 rtl/snax_cgra_cfg_loader.sv | 180 ++++++++++++++++++
 tb/tb_snax_cgra_cfg_loader.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snax_cgra_cfg_loader.sv
// Streams a CGRA configuration image out of TCDM into the tile config slots,
// one word per read, ordered by ascending tile then ascending slot.
//
//   state | meaning
//   IDLE  | waiting for start_i
//   REQ   | read request for (tile, slot) on the TCDM port
//   WAIT  | read accepted, waiting for the response word
//   PUSH  | config word offered to the target tile
//   DONE  | one-cycle completion / abort pulse
module snax_cgra_cfg_loader #(
  parameter int TCDMAddrWidth = 48,
  parameter int DataWidth     = 64,
  parameter int NumTiles      = 16,
  parameter int KernelSize    = 4,
  parameter int CfgWidth      = 49,
  localparam int TileW = (NumTiles > 1) ? $clog2(NumTiles) : 1,
  localparam int SlotW = (KernelSize > 1) ? $clog2(KernelSize) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [TCDMAddrWidth-1:0] base_addr_i,
  input  logic [NumTiles-1:0]      tile_mask_i,
  input  logic                     abort_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     tcdm_q_valid_o,
  output logic [TCDMAddrWidth-1:0] tcdm_q_addr_o,
  output logic                     tcdm_q_write_o,
  input  logic                     tcdm_q_ready_i,
  input  logic                     tcdm_p_valid_i,
  input  logic [DataWidth-1:0]     tcdm_p_data_i,
  output logic                     cfg_valid_o,
  output logic [TileW-1:0]         cfg_tile_o,
  output logic [SlotW-1:0]         cfg_slot_o,
  output logic [CfgWidth-1:0]      cfg_data_o,
  input  logic [NumTiles-1:0]      cfg_ready_i
);

  localparam int WordBytes = DataWidth / 8;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, PUSH, DONE} state_e;

  state_e                   state_q, state_d;
  logic [TCDMAddrWidth-1:0] base_q, base_d;
  logic [NumTiles-1:0]      mask_q, mask_d;
  logic [TileW-1:0]         tile_q, tile_d;
  logic [SlotW-1:0]         slot_q, slot_d;
  logic [CfgWidth-1:0]      data_q, data_d;
  logic                     abort_pend_q, abort_pend_d;

  logic [TileW-1:0]         first_tile, nxt_tile;
  logic                     first_found, nxt_found;
  logic [TCDMAddrWidth-1:0] word_idx, addr_off;

  // Lowest enabled tile of the incoming mask, and the next enabled tile above
  // the current one in the latched mask.
  always_comb begin
    first_tile  = '0;
    first_found = 1'b0;
    nxt_tile    = '0;
    nxt_found   = 1'b0;
    for (int t = NumTiles - 1; t >= 0; t--) begin
      if (tile_mask_i[t]) begin
        first_tile  = TileW'(t);
        first_found = 1'b1;
      end
      if (mask_q[t] && (t > int'(tile_q))) begin
        nxt_tile  = TileW'(t);
        nxt_found = 1'b1;
      end
    end
  end

  // Addresses use the absolute tile number, so skipped tiles leave holes.
  assign word_idx = TCDMAddrWidth'(tile_q) * TCDMAddrWidth'(KernelSize)
                  + TCDMAddrWidth'(slot_q);
  assign addr_off = word_idx * TCDMAddrWidth'(WordBytes);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      base_q       <= '0;
      mask_q       <= '0;
      tile_q       <= '0;
      slot_q       <= '0;
      data_q       <= '0;
      abort_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      mask_q       <= mask_d;
      tile_q       <= tile_d;
      slot_q       <= slot_d;
      data_q       <= data_d;
      abort_pend_q <= abort_pend_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    mask_d       = mask_q;
    tile_d       = tile_q;
    slot_d       = slot_q;
    data_d       = data_q;
    abort_pend_d = abort_pend_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          base_d       = base_addr_i;
          mask_d       = tile_mask_i;
          tile_d       = first_tile;
          slot_d       = '0;
          abort_pend_d = 1'b0;
          state_d      = first_found ? REQ : DONE;
        end
      end
      REQ: begin
        if (tcdm_q_ready_i) begin
          // An accepted read must still be drained before finishing.
          abort_pend_d = abort_i;
          state_d      = WAIT;
        end else if (abort_i) begin
          state_d = DONE;
        end
      end
      WAIT: begin
        if (tcdm_p_valid_i) begin
          if (abort_pend_q || abort_i) begin
            state_d = DONE;
          end else begin
            data_d  = tcdm_p_data_i[CfgWidth-1:0];
            state_d = PUSH;
          end
        end else if (abort_i) begin
          abort_pend_d = 1'b1;
        end
      end
      PUSH: begin
        if (abort_i) begin
          state_d = DONE;
        end else if (cfg_ready_i[tile_q]) begin
          if (slot_q != SlotW'(KernelSize - 1)) begin
            slot_d  = slot_q + SlotW'(1);
            state_d = REQ;
          end else if (nxt_found) begin
            tile_d  = nxt_tile;
            slot_d  = '0;
            state_d = REQ;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        abort_pend_d = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o         = (state_q == REQ) || (state_q == WAIT) || (state_q == PUSH);
  assign done_o         = (state_q == DONE);
  assign tcdm_q_valid_o = (state_q == REQ);
  assign tcdm_q_addr_o  = base_q + addr_off;
  assign tcdm_q_write_o = 1'b0;
  assign cfg_valid_o    = (state_q == PUSH);
  assign cfg_tile_o     = tile_q;
  assign cfg_slot_o     = slot_q;
  assign cfg_data_o     = data_q;

  if (DataWidth > CfgWidth) begin : g_unused_hi
    logic unused_data_hi;
    assign unused_data_hi = ^tcdm_p_data_i[DataWidth-1:CfgWidth];
  end

endmodule

// File: tb/tb_snax_cgra_cfg_loader.sv
// Randomized and directed bench for snax_cgra_cfg_loader against a
// transaction-level model built from the expected read/write sequence.
module tb_snax_cgra_cfg_loader;

  localparam int AW = 48;
  localparam int DW = 64;
  localparam int NT = 16;
  localparam int KS = 4;
  localparam int CW = 49;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic [AW-1:0] base_addr_i;
  logic [NT-1:0] tile_mask_i;
  logic          abort_i;
  logic          busy_o, done_o;
  logic          tcdm_q_valid_o, tcdm_q_write_o, tcdm_q_ready_i;
  logic [AW-1:0] tcdm_q_addr_o;
  logic          tcdm_p_valid_i;
  logic [DW-1:0] tcdm_p_data_i;
  logic          cfg_valid_o;
  logic [3:0]    cfg_tile_o;
  logic [1:0]    cfg_slot_o;
  logic [CW-1:0] cfg_data_o;
  logic [NT-1:0] cfg_ready_i;

  snax_cgra_cfg_loader #(
    .TCDMAddrWidth(AW), .DataWidth(DW), .NumTiles(NT), .KernelSize(KS), .CfgWidth(CW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .base_addr_i(base_addr_i),
    .tile_mask_i(tile_mask_i), .abort_i(abort_i), .busy_o(busy_o), .done_o(done_o),
    .tcdm_q_valid_o(tcdm_q_valid_o), .tcdm_q_addr_o(tcdm_q_addr_o),
    .tcdm_q_write_o(tcdm_q_write_o), .tcdm_q_ready_i(tcdm_q_ready_i),
    .tcdm_p_valid_i(tcdm_p_valid_i), .tcdm_p_data_i(tcdm_p_data_i),
    .cfg_valid_o(cfg_valid_o), .cfg_tile_o(cfg_tile_o), .cfg_slot_o(cfg_slot_o),
    .cfg_data_o(cfg_data_o), .cfg_ready_i(cfg_ready_i)
  );

  initial forever #5 clk_i = ~clk_i;

  typedef struct {
    logic [AW-1:0] addr;
    int            tile;
    int            slot;
    logic [CW-1:0] data;
  } word_t;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;

  // model state
  word_t rd_q[$];
  word_t wr_q[$];
  bit m_req = 0, m_wait = 0, m_push = 0, m_done = 0, m_pend = 0;

  // observation logs
  logic [AW-1:0] rd_log[$];
  word_t         wr_log[$];
  int rd_cnt = 0, done_cnt = 0;
  int done_cyc = 0, pv_cyc = 0, last_wr_cyc = 0, start_cyc = 0;
  int done_base = 0, rd_base = 0;
  logic [AW-1:0] last_rd_addr = '0;

  // memory / tile behaviour knobs
  int q_pct = 100, c_pct = 100, lat_max = 0, fix_lat = 0;
  bit q_hold = 0, c_hold = 0;

  function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
    logic [31:0] lo, hi;
    lo = a[31:0] ^ 32'hA5A5_3C3C;
    hi = a[31:0] * 32'h9E37_79B1 + {16'h0, a[47:32]};
    return {hi, lo};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out (cycle %0d)", nm, cyc);
  endtask

  task automatic build(input logic [AW-1:0] b, input logic [NT-1:0] m);
    rd_q.delete();
    wr_q.delete();
    for (int t = 0; t < NT; t++) begin
      if (m[t]) begin
        for (int s = 0; s < KS; s++) begin
          word_t w;
          logic [DW-1:0] d;
          w.addr = b + AW'((t * KS + s) * (DW / 8));
          w.tile = t;
          w.slot = s;
          d      = mem_data(w.addr);
          w.data = d[CW-1:0];
          rd_q.push_back(w);
          wr_q.push_back(w);
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  // memory and tile responder
  initial begin
    int rsp_seen = 0, rsp_cd = 0;
    bit rsp_pend = 0;
    logic [AW-1:0] rsp_addr = '0;
    tcdm_q_ready_i = 1'b0;
    tcdm_p_valid_i = 1'b0;
    tcdm_p_data_i  = '0;
    cfg_ready_i    = '0;
    forever begin
      @(posedge clk_i);
      #1;
      tcdm_q_ready_i = !q_hold && ($urandom_range(99) < q_pct);
      for (int t = 0; t < NT; t++) cfg_ready_i[t] = !c_hold && ($urandom_range(99) < c_pct);
      tcdm_p_valid_i = 1'b0;
      tcdm_p_data_i  = {$urandom(), $urandom()};
      if (rd_cnt != rsp_seen) begin
        rsp_seen = rd_cnt;
        rsp_pend = 1;
        rsp_addr = last_rd_addr;
        rsp_cd   = (fix_lat >= 0) ? fix_lat : int'($urandom_range(lat_max));
      end
      if (rsp_pend) begin
        if (rsp_cd == 0) begin
          tcdm_p_valid_i = 1'b1;
          tcdm_p_data_i  = mem_data(rsp_addr);
          rsp_pend       = 0;
        end else begin
          rsp_cd--;
        end
      end
    end
  end

  // compare process: DUT outputs against the model every cycle
  initial forever begin
    @(negedge clk_i);
    if (rst_i) begin
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_q_valid", tcdm_q_valid_o, 0);
      chk("rst_cfg_valid", cfg_valid_o, 0);
      chk("rst_q_addr", tcdm_q_addr_o, 0);
      chk("rst_cfg_data", cfg_data_o, 0);
      chk("rst_cfg_idx", {cfg_tile_o, cfg_slot_o}, 0);
      m_req = 0; m_wait = 0; m_push = 0; m_done = 0; m_pend = 0;
      rd_q.delete();
      wr_q.delete();
    end else begin
      chk("busy", busy_o, m_req | m_wait | m_push);
      chk("done", done_o, m_done);
      chk("q_valid", tcdm_q_valid_o, m_req);
      chk("cfg_valid", cfg_valid_o, m_push);
      chk("q_write", tcdm_q_write_o, 0);
      if (m_req && rd_q.size() > 0) chk("q_addr", tcdm_q_addr_o, rd_q[0].addr);
      if (m_push && wr_q.size() > 0) begin
        chk("cfg_tile", cfg_tile_o, wr_q[0].tile);
        chk("cfg_slot", cfg_slot_o, wr_q[0].slot);
        chk("cfg_data", cfg_data_o, wr_q[0].data);
      end

      if (tcdm_q_valid_o && tcdm_q_ready_i) begin
        rd_cnt++;
        last_rd_addr = tcdm_q_addr_o;
        rd_log.push_back(tcdm_q_addr_o);
      end
      if (cfg_valid_o && cfg_ready_i[cfg_tile_o]) begin
        word_t w;
        w.addr = '0;
        w.tile = int'(cfg_tile_o);
        w.slot = int'(cfg_slot_o);
        w.data = cfg_data_o;
        wr_log.push_back(w);
        last_wr_cyc = cyc;
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (tcdm_p_valid_i) pv_cyc = cyc;

      if (m_done) begin
        m_done = 0;
      end else if (m_req) begin
        if (tcdm_q_ready_i) begin
          if (rd_q.size() > 0) void'(rd_q.pop_front());
          m_req  = 0;
          m_wait = 1;
          m_pend = abort_i;
        end else if (abort_i) begin
          m_req = 0;
          m_done = 1;
          rd_q.delete();
          wr_q.delete();
        end
      end else if (m_wait) begin
        if (tcdm_p_valid_i) begin
          m_wait = 0;
          if (m_pend || abort_i) begin
            m_done = 1;
            rd_q.delete();
            wr_q.delete();
          end else begin
            m_push = 1;
          end
        end else if (abort_i) begin
          m_pend = 1;
        end
      end else if (m_push) begin
        bit hs;
        hs = (wr_q.size() > 0) && cfg_ready_i[wr_q[0].tile];
        if (hs) void'(wr_q.pop_front());
        if (abort_i) begin
          m_push = 0;
          m_done = 1;
          rd_q.delete();
          wr_q.delete();
        end else if (hs) begin
          m_push = 0;
          if (rd_q.size() > 0) m_req = 1;
          else m_done = 1;
        end
      end else if (start_i) begin
        build(base_addr_i, tile_mask_i);
        m_pend = 0;
        if (tile_mask_i == '0) m_done = 1;
        else m_req = 1;
      end
    end
  end

  task automatic start_load(input logic [AW-1:0] b, input logic [NT-1:0] m);
    @(posedge clk_i);
    #1;
    rd_log.delete();
    wr_log.delete();
    done_base   = done_cnt;
    rd_base     = rd_cnt;
    base_addr_i = b;
    tile_mask_i = m;
    start_i     = 1'b1;
    start_cyc   = cyc;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk_i);
      #1;
      if (done_cnt != done_base) return;
    end
    fail_now(nm);
  endtask

  task automatic wait_rd(input string nm);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      if (rd_cnt != rd_base) return;
    end
    fail_now(nm);
  endtask

  task automatic wait_cfg_valid(input string nm);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      if (cfg_valid_o) return;
    end
    fail_now(nm);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d;
    rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0;
    base_addr_i = '0; tile_mask_i = '0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;

    // single tile, zero-wait
    start_load(48'h1000, 16'h0001);
    wait_done("t1_done", 200);
    chk("t1_cycles", done_cyc - start_cyc, 13);
    chk("t1_done_after_hs", done_cyc - last_wr_cyc, 1);
    chk("t1_nrd", rd_log.size(), 4);
    chk("t1_nwr", wr_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < rd_log.size()) chk("t1_rd_addr", rd_log[i], 48'h1000 + 48'(8 * i));
      if (i < wr_log.size()) begin
        d = mem_data(48'h1000 + 48'(8 * i));
        chk("t1_wr_tile", wr_log[i].tile, 0);
        chk("t1_wr_slot", wr_log[i].slot, i);
        chk("t1_wr_data", wr_log[i].data, d[CW-1:0]);
      end
    end

    // sparse mask, tiles 1 and 15
    start_load(48'h4000, 16'h8002);
    wait_done("t2_done", 200);
    chk("t2_nrd", rd_log.size(), 8);
    chk("t2_nwr", wr_log.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < rd_log.size())
        chk("t2_rd_addr", rd_log[i], (i < 4) ? 48'h4020 + 48'(8 * i) : 48'h41E0 + 48'(8 * (i - 4)));
      if (i < wr_log.size()) chk("t2_wr_tile", wr_log[i].tile, (i < 4) ? 1 : 15);
    end

    // empty mask
    start_load(48'h1000, 16'h0000);
    wait_done("t3_done", 20);
    chk("t3_cycles", done_cyc - start_cyc, 1);
    chk("t3_nrd", rd_log.size(), 0);
    chk("t3_nwr", wr_log.size(), 0);

    // back-pressure on both sides
    q_hold = 1; c_hold = 1;
    start_load(48'h0, 16'h0004);
    repeat (5) @(posedge clk_i);
    #1;
    chk("t4_rd_during_hold", rd_log.size(), 0);
    q_hold = 0;
    wait_cfg_valid("t4_cfg_valid");
    repeat (3) @(posedge clk_i);
    #1;
    chk("t4_rd_before_cfg", rd_log.size(), 1);
    chk("t4_wr_during_hold", wr_log.size(), 0);
    c_hold = 0;
    wait_done("t4_done", 200);
    chk("t4_nrd", rd_log.size(), 4);
    chk("t4_nwr", wr_log.size(), 4);
    if (rd_log.size() > 0) chk("t4_rd0", rd_log[0], 48'h40);

    // abort while waiting for the response
    fix_lat = 4;
    start_load(48'h2000, 16'h0001);
    wait_rd("t5_rd");
    @(posedge clk_i);
    #1 abort_i = 1'b1;
    @(posedge clk_i);
    #1 abort_i = 1'b0;
    wait_done("t5_done", 50);
    chk("t5_done_after_pv", done_cyc - pv_cyc, 1);
    chk("t5_nwr", wr_log.size(), 0);
    @(negedge clk_i);
    chk("t5_busy_after", busy_o, 0);

    // address wrap
    fix_lat = 0;
    start_load(48'hFFFF_FFFF_FFF8, 16'h0001);
    wait_done("t6_done", 200);
    if (rd_log.size() >= 3) begin
      chk("t6_rd0", rd_log[0], 48'hFFFF_FFFF_FFF8);
      chk("t6_rd1_wrap", rd_log[1], 48'h0);
      chk("t6_rd2", rd_log[2], 48'h8);
    end else begin
      chk("t6_nrd", rd_log.size(), 4);
    end

    // reset during PUSH
    c_hold = 1;
    start_load(48'h3000, 16'h0010);
    wait_cfg_valid("t7_cfg_valid");
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    #1;
    chk("t7_cfg_valid_rst", cfg_valid_o, 0);
    chk("t7_busy_rst", busy_o, 0);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    c_hold = 0;
    repeat (5) @(posedge clk_i);
    #1;
    chk("t7_busy_after", busy_o, 0);
    chk("t7_nwr", wr_log.size(), 0);

    // reset during WAIT, stale response afterwards
    fix_lat = 3;
    start_load(48'h5000, 16'h0001);
    wait_rd("t8_rd");
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    repeat (8) @(posedge clk_i);
    #1;
    chk("t8_busy_after", busy_o, 0);
    chk("t8_nwr", wr_log.size(), 0);

    // randomized loads with back-pressure, aborts and ignored restarts
    for (int k = 0; k < 40; k++) begin
      logic [63:0] r64;
      logic [NT-1:0] m;
      int abort_pct;
      bit aborted, timed_out;
      q_pct   = 40 + int'($urandom_range(60));
      c_pct   = 40 + int'($urandom_range(60));
      lat_max = int'($urandom_range(3));
      fix_lat = -1;
      abort_pct = (k % 3 == 0) ? 4 : 0;
      r64 = {$urandom(), $urandom()};
      m = (k % 4 == 0) ? NT'($urandom()) : NT'($urandom() & $urandom() & $urandom());
      aborted = 0;
      timed_out = 1;
      start_load(r64[AW-1:0], m);
      for (int i = 0; i < 2000; i++) begin
        @(posedge clk_i);
        #1;
        if (done_cnt != done_base) begin
          timed_out = 0;
          break;
        end
        abort_i = busy_o && ($urandom_range(99) < abort_pct);
        if (abort_i) aborted = 1;
        start_i = busy_o && ($urandom_range(99) < 5);
        r64 = {$urandom(), $urandom()};
        base_addr_i = r64[AW-1:0];
        tile_mask_i = NT'($urandom());
      end
      abort_i = 1'b0;
      start_i = 1'b0;
      if (timed_out) fail_now("rnd_done");
      if (!aborted) chk("rnd_nwr", wr_log.size(), $countones(m) * KS);
    end

    repeat (3) @(posedge clk_i);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
